// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg
//   Shared definitions for the ID/EX pipeline slice:
//     - datapath, register-address and ALU-opcode widths
//     - ALU opcode constants
//     - ID/EX control bundle struct and a helper that kills its side effects
// ---------------------------------------------------------------------------
package pipe_pkg;

   localparam int DW  = 16;  // datapath / ALU operand width
   localparam int RW  = 3;   // register address width (r0 hard-wired zero)
   localparam int OPW = 4;   // ALU operation code width

   localparam logic [OPW-1:0] ALU_ADD = 4'b0000;
   localparam logic [OPW-1:0] ALU_SUB = 4'b0001;
   localparam logic [OPW-1:0] ALU_AND = 4'b0010;
   localparam logic [OPW-1:0] ALU_OR  = 4'b0011;
   localparam logic [OPW-1:0] ALU_XOR = 4'b0100;

   // Control bundle carried from decode into execute.
   typedef struct packed {
      logic [OPW-1:0] aluop;
      logic           use_imm;
      logic           regwrite;
      logic           memread;
      logic           memwrite;
   } idex_ctrl_t;

   // Clear only the bits that cause architectural side effects; the ALU
   // operation and operand select are harmless in a dead slot.
   function automatic idex_ctrl_t kill_ctrl(input idex_ctrl_t c);
      idex_ctrl_t k;
      k          = c;
      k.regwrite = 1'b0;
      k.memread  = 1'b0;
      k.memwrite = 1'b0;
      return k;
   endfunction

endpackage

// File: rtl/fwd_mux.sv
// ---------------------------------------------------------------------------
// fwd_mux
//   Combinational operand-forwarding selector for one source register.
//   Priority: EX/MEM result, then MEM/WB data, then the registered
//   register-file value. r0 is never a forwarding source.
//
// Ports:
//   rs_i            source register address held in ID/EX
//   rdata_i         register-file value captured with that address
//   exm_regwrite_i  EX/MEM instruction writes a register
//   exm_rd_i        EX/MEM destination
//   exm_result_i    EX/MEM ALU result
//   mwb_regwrite_i  MEM/WB instruction writes a register
//   mwb_rd_i        MEM/WB destination
//   mwb_data_i      MEM/WB write-back data
//   fwd_o           selected operand value
// ---------------------------------------------------------------------------
module fwd_mux
   import pipe_pkg::*;
#(
   parameter int W  = DW,
   parameter int AW = RW
) (
   input  logic [AW-1:0] rs_i,
   input  logic [W-1:0]  rdata_i,
   input  logic          exm_regwrite_i,
   input  logic [AW-1:0] exm_rd_i,
   input  logic [W-1:0]  exm_result_i,
   input  logic          mwb_regwrite_i,
   input  logic [AW-1:0] mwb_rd_i,
   input  logic [W-1:0]  mwb_data_i,
   output logic [W-1:0]  fwd_o
);

   logic exm_hit;
   logic mwb_hit;

   // A write to r0 is discarded by the register file, so it must never
   // override the (zero) value read for r0.
   assign exm_hit = exm_regwrite_i && (exm_rd_i != '0) && (exm_rd_i == rs_i);
   assign mwb_hit = mwb_regwrite_i && (mwb_rd_i != '0) && (mwb_rd_i == rs_i);

   // NOTE: every path assigns fwd_o (if/else-if/else), so no latch is
   // inferred; an always_comb with a missing branch would hold state.
   always_comb begin
      if (exm_hit) begin
         fwd_o = exm_result_i;        // youngest producer wins
      end else if (mwb_hit) begin
         fwd_o = mwb_data_i;
      end else begin
         fwd_o = rdata_i;
      end
   end

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register plus operand-forwarding front end for the
//   16-bit execute ALU. Detects load-use hazards (bubble + decode stall),
//   honours branch flush and downstream hold, and keeps a saturating count
//   of inserted bubbles.
//
// Ports:
//   clk, rst                     clock (rising edge), async active-high reset
//   id_valid                     decode holds a valid instruction
//   id_rs1/id_rs2/id_rd          source / destination register addresses
//   id_rdata1/id_rdata2          register-file read data
//   id_imm, id_use_imm           sign-extended immediate, operand-2 select
//   id_aluop                     ALU operation
//   id_regwrite/memread/memwrite decoded control bits
//   exm_regwrite/exm_rd/exm_result  EX/MEM forwarding source
//   mwb_regwrite/mwb_rd/mwb_data    MEM/WB forwarding source
//   flush                        branch taken: kill the instruction entering EX
//   hold                         downstream busy: freeze this stage
//   ex_valid                     EX holds a valid instruction
//   ex_data1/ex_data2            forwarded ALU operands
//   ex_aluop, ex_rd              registered ALU operation / destination
//   ex_store_data                forwarded rs2 value for stores
//   ex_regwrite/memread/memwrite registered control, gated by ex_valid
//   stall_id                     hold IF/ID this cycle
//   bubble_count                 saturating count of inserted bubbles
// ---------------------------------------------------------------------------
module id_ex_stage
   import pipe_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   input  logic           id_valid,
   input  logic [RW-1:0]  id_rs1,
   input  logic [RW-1:0]  id_rs2,
   input  logic [RW-1:0]  id_rd,
   input  logic [DW-1:0]  id_rdata1,
   input  logic [DW-1:0]  id_rdata2,
   input  logic [DW-1:0]  id_imm,
   input  logic           id_use_imm,
   input  logic [OPW-1:0] id_aluop,
   input  logic           id_regwrite,
   input  logic           id_memread,
   input  logic           id_memwrite,
   input  logic           exm_regwrite,
   input  logic [RW-1:0]  exm_rd,
   input  logic [DW-1:0]  exm_result,
   input  logic           mwb_regwrite,
   input  logic [RW-1:0]  mwb_rd,
   input  logic [DW-1:0]  mwb_data,
   input  logic           flush,
   input  logic           hold,
   output logic           ex_valid,
   output logic [DW-1:0]  ex_data1,
   output logic [DW-1:0]  ex_data2,
   output logic [OPW-1:0] ex_aluop,
   output logic [DW-1:0]  ex_store_data,
   output logic [RW-1:0]  ex_rd,
   output logic           ex_regwrite,
   output logic           ex_memread,
   output logic           ex_memwrite,
   output logic           stall_id,
   output logic [15:0]    bubble_count
);

   // ---------------------------------------------------------------------
   // ID/EX state
   // ---------------------------------------------------------------------
   logic          valid_q,  valid_d;
   idex_ctrl_t    ctrl_q,   ctrl_d;
   logic [RW-1:0] rs1_q,    rs1_d;
   logic [RW-1:0] rs2_q,    rs2_d;
   logic [RW-1:0] rd_q,     rd_d;
   logic [DW-1:0] rdata1_q, rdata1_d;
   logic [DW-1:0] rdata2_q, rdata2_d;
   logic [DW-1:0] imm_q,    imm_d;
   logic [15:0]   bubble_q, bubble_d;

   logic          loaduse;
   logic [DW-1:0] fwd_rs1;
   logic [DW-1:0] fwd_rs2;

   // ---------------------------------------------------------------------
   // Load-use hazard: the load's data is not available until MEM, so a
   // dependent instruction must wait one cycle. rs2 is compared even for
   // immediate-form instructions because stores read it as store data.
   // ---------------------------------------------------------------------
   assign loaduse = ex_valid && ex_memread && id_valid && (ex_rd != '0) &&
                    ((id_rs1 == ex_rd) || (id_rs2 == ex_rd));

   // A flush discards whatever decode holds, so stalling it is pointless.
   assign stall_id = !flush && (hold || loaduse);

   // ---------------------------------------------------------------------
   // Next-state selection: flush > hold > load-use bubble > capture.
   // ---------------------------------------------------------------------
   always_comb begin
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      rs1_d    = rs1_q;
      rs2_d    = rs2_q;
      rd_d     = rd_q;
      rdata1_d = rdata1_q;
      rdata2_d = rdata2_q;
      imm_d    = imm_q;
      bubble_d = bubble_q;

      if (flush) begin
         valid_d = 1'b0;
         ctrl_d  = kill_ctrl(ctrl_q);
      end else if (hold) begin
         // keep everything
      end else if (loaduse) begin
         valid_d = 1'b0;
         ctrl_d  = kill_ctrl(ctrl_q);
         if (bubble_q != 16'hFFFF) begin
            bubble_d = bubble_q + 16'd1;
         end
      end else begin
         valid_d  = id_valid;
         ctrl_d   = '{aluop:    id_aluop,
                      use_imm:  id_use_imm,
                      regwrite: id_regwrite && id_valid,
                      memread:  id_memread  && id_valid,
                      memwrite: id_memwrite && id_valid};
         rs1_d    = id_rs1;
         rs2_d    = id_rs2;
         rd_d     = id_rd;
         rdata1_d = id_rdata1;
         rdata2_d = id_rdata2;
         imm_d    = id_imm;
      end
   end

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q  <= 1'b0;
         ctrl_q   <= '0;
         rs1_q    <= '0;
         rs2_q    <= '0;
         rd_q     <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         imm_q    <= '0;
         bubble_q <= '0;
      end else begin
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         rs1_q    <= rs1_d;
         rs2_q    <= rs2_d;
         rd_q     <= rd_d;
         rdata1_q <= rdata1_d;
         rdata2_q <= rdata2_d;
         imm_q    <= imm_d;
         bubble_q <= bubble_d;
      end
   end

   // ---------------------------------------------------------------------
   // Operand forwarding, one selector per source register
   // ---------------------------------------------------------------------
   fwd_mux #(.W(DW), .AW(RW)) u_fwd_rs1 (
      .rs_i           (rs1_q),
      .rdata_i        (rdata1_q),
      .exm_regwrite_i (exm_regwrite),
      .exm_rd_i       (exm_rd),
      .exm_result_i   (exm_result),
      .mwb_regwrite_i (mwb_regwrite),
      .mwb_rd_i       (mwb_rd),
      .mwb_data_i     (mwb_data),
      .fwd_o          (fwd_rs1)
   );

   fwd_mux #(.W(DW), .AW(RW)) u_fwd_rs2 (
      .rs_i           (rs2_q),
      .rdata_i        (rdata2_q),
      .exm_regwrite_i (exm_regwrite),
      .exm_rd_i       (exm_rd),
      .exm_result_i   (exm_result),
      .mwb_regwrite_i (mwb_regwrite),
      .mwb_rd_i       (mwb_rd),
      .mwb_data_i     (mwb_data),
      .fwd_o          (fwd_rs2)
   );

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign ex_valid      = valid_q;
   assign ex_data1      = fwd_rs1;
   assign ex_store_data = fwd_rs2;
   assign ex_data2      = ctrl_q.use_imm ? imm_q : fwd_rs2;
   assign ex_aluop      = ctrl_q.aluop;
   assign ex_rd         = rd_q;
   // Gate side-effecting control so a dead slot can never write.
   assign ex_regwrite   = valid_q && ctrl_q.regwrite;
   assign ex_memread    = valid_q && ctrl_q.memread;
   assign ex_memwrite   = valid_q && ctrl_q.memwrite;
   assign bubble_count  = bubble_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-forwarding front end that feeds the 16-bit execute ALU (data1, data2, 4-bit aluoperation).
- Captures decoded operands and control at each clock edge and resolves EX/MEM and MEM/WB forwarding.
- Detects load-use hazards, inserting a bubble and stalling decode.
- Handles branch flush and downstream hold, and keeps a saturating bubble counter for performance monitoring.

Parameters:
- DW, 16, datapath width (ALU operand width).
- RW, 3, register-address width (8 registers; r0 reads as zero and is never a forwarding source).
- OPW, 4, ALU operation code width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_valid  in  1  decode stage holds a valid instruction.
- id_rs1, id_rs2, id_rd  in  RW  source/destination register addresses.
- id_rdata1, id_rdata2  in  DW  register-file read data.
- id_imm  in  DW  sign-extended immediate.
- id_use_imm  in  1  ALU operand 2 comes from the immediate.
- id_aluop  in  OPW  ALU operation (0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR).
- id_regwrite, id_memread, id_memwrite  in  1  control bits.
- exm_regwrite  in  1  EX/MEM instruction writes a register.
- exm_rd  in  RW  EX/MEM destination register.
- exm_result  in  DW  EX/MEM ALU result.
- mwb_regwrite  in  1  MEM/WB instruction writes a register.
- mwb_rd  in  RW  MEM/WB destination register.
- mwb_data  in  DW  MEM/WB write-back data.
- flush  in  1  branch taken; kill the instruction entering EX.
- hold  in  1  downstream busy; freeze this stage.
- ex_valid  out  1  EX holds a valid instruction.
- ex_data1, ex_data2  out  DW  forwarded ALU operands.
- ex_aluop  out  OPW  registered ALU operation.
- ex_store_data  out  DW  forwarded rs2 value, for stores.
- ex_rd  out  RW  registered destination register.
- ex_regwrite, ex_memread, ex_memwrite  out  1  registered control, gated by ex_valid.
- stall_id  out  1  hold IF/ID this cycle.
- bubble_count  out  16  saturating count of inserted bubbles.

Behaviour:
- Reset (async, rst=1):
  - All registered fields clear to 0: ex_valid, control bits, aluop, rd, operands, immediate, use_imm.
  - bubble_count = 0.
  - Outputs follow combinationally: ex_data1=ex_data2=ex_store_data=0, stall_id=0.
  - Asserting rst mid-stall drops the stalled instruction; there is no replay.
- Load-use hazard (combinational), loaduse:
  - Condition: ex_valid & ex_memread & id_valid & ex_rd!=0 & (id_rs1==ex_rd | id_rs2==ex_rd).
  - rs2 is checked even when id_use_imm=1, because a store needs rs2.
- stall_id = ~flush & (hold | loaduse).
- Register update at each rising clk, in priority order:
  1. flush=1: ex_valid<=0 and control bits <=0. Overrides hold and loaduse. No bubble is counted.
  2. hold=1: all registers keep their values.
  3. loaduse=1: a bubble is loaded (ex_valid<=0, control<=0, operands don't-care). bubble_count increments, saturating at 16'hFFFF.
  4. Otherwise: capture all id_* fields. ex_valid<=id_valid. Control bits are ANDed with id_valid.
- Latency: one cycle from the id_* inputs to the ex_* outputs.
- Forwarding (combinational, applied to the registered rs1 and rs2 independently):
  - If exm_regwrite & exm_rd!=0 & exm_rd==rsN, select exm_result.
  - Else if mwb_regwrite & mwb_rd!=0 & mwb_rd==rsN, select mwb_data.
  - Else select the registered rdataN.
  - EX/MEM takes priority over MEM/WB when both match.
- Operand outputs:
  - ex_data1 = forwarded rs1.
  - ex_store_data = forwarded rs2.
  - ex_data2 = registered id_imm if use_imm=1, else forwarded rs2.
- A source register of r0 never forwards and passes the registered value through unchanged.
- Control outputs are forced to 0 whenever ex_valid=0, so a bubble never writes.

Decomposition:
- Shared package pipe_pkg holds:
  - DW, RW, OPW.
  - ALU opcode constants: ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR.
  - A struct for the ID/EX control bundle (aluop, use_imm, regwrite, memread, memwrite).
- One sub-module, fwd_mux: a purely combinational forwarding selector for one operand. It is instantiated twice (rs1, rs2).
- The hazard logic and registers live in the top module.

Test Plan:
- Plain ADD: id_rs1=1 (rdata 0x0005), id_rs2=2 (0x0003), aluop 0000, no forwarding. One cycle later: ex_data1=0x0005, ex_data2=0x0003, ex_valid=1.
- EX/MEM forwarding: EX holds rs1=3 (rdata 0x1111), exm_regwrite=1, exm_rd=3, exm_result=0xABCD. Also mwb_rd=3, mwb_data=0x2222. Required: ex_data1=0xABCD (EX/MEM wins over MEM/WB).
- r0 guard: EX holds rs1=0 (rdata 0x0000), exm_regwrite=1, exm_rd=0, exm_result=0xFFFF. Required: ex_data1=0x0000.
- Load-use: EX holds memread=1, rd=4. ID presents rs2=4 with use_imm=1. Required: stall_id=1 that cycle; next cycle ex_valid=0, ex_regwrite=0; bubble_count 0->1. The following cycle ID is captured and ex_valid=1.
- Flush vs hold: flush=1 and hold=1 together with a load-use condition. Required: stall_id=0; next cycle ex_valid=0; bubble_count unchanged.
- Async reset: rst pulses mid-cycle while ex_valid=1 and bubble_count=7. Required: ex_valid=0 and bubble_count=0 immediately, before the next clock edge.
